// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receive engine.
// Filters the raw lines, deframes 11-bit frames, buffers one byte.
module ps2_rx_core #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] dat_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       par_err_o,
    output logic       frm_err_o,
    output logic       ovf_o
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          filt_clk;
    logic          filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          par_ok;

    // Synchronise both lines and debounce the clock line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk_i;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_dat_i;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall   = filt_prev & ~filt_clk;
    assign par_ok = ^{shreg, par_bit};

    // Frame FSM, timeout, output buffer and status pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            dat_o     <= '0;
            valid_o   <= 1'b0;
            par_err_o <= 1'b0;
            frm_err_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            par_err_o <= 1'b0;
            frm_err_o <= 1'b0;
            ovf_o     <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (fall) begin
                tmo_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!par_ok) begin
                            par_err_o <= 1'b1;
                        end else if (!dat_s2) begin
                            frm_err_o <= 1'b1;
                        end else if (!valid_o || ready_i) begin
                            dat_o   <= shreg;
                            valid_o <= 1'b1;
                        end else begin
                            ovf_o <= 1'b1;
                        end
                    end
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_MAX) begin
                    state     <= IDLE;
                    frm_err_o <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_core.sv
// Randomised self-checking bench for ps2_rx_core.
// Frame outcomes are predicted from the PS/2 framing rules.
module tb_ps2_rx_core;

    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] dat;
    logic       valid;
    logic       ready;
    logic       par_err;
    logic       frm_err;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;
    int frm_at = 0;

    int       exp_par = 0;
    int       exp_frm = 0;
    int       exp_ovf = 0;
    bit       m_valid = 0;
    bit [7:0] m_dat = 0;

    ps2_rx_core #(
        .FILT_LEN   (4),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .dat_o    (dat),
        .valid_o  (valid),
        .ready_i  (ready),
        .par_err_o(par_err),
        .frm_err_o(frm_err),
        .ovf_o    (ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Count high cycles of each pulse output.
    always @(negedge clk) begin
        if (par_err) n_par++;
        if (frm_err) begin
            n_frm++;
            frm_at = cyc;
        end
        if (ovf) n_ovf++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_dat"}, 32'(dat), 32'(m_dat));
        check({tag, "_par"}, n_par, exp_par);
        check({tag, "_frm"}, n_frm, exp_frm);
        check({tag, "_ovf"}, n_ovf, exp_ovf);
    endtask

    // One bit cell; optional high glitch inside the low phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 0;
        if (glitch) begin
            wait_cyc(8);
            ps2_clk = 1;
            wait_cyc(3);
            ps2_clk = 0;
            wait_cyc(HALF - 11);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1;
    endtask

    task automatic frame(input bit [7:0] d, input bit par, input bit stop,
                         input bit glitch, input bit watch);
        bit bits[11];
        bit seen;
        bits[0] = 0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9] = par;
        bits[10] = stop;
        if (glitch) begin
            ps2_clk = 0;
            wait_cyc(2);
            ps2_clk = 1;
            wait_cyc(10);
        end
        for (int i = 0; i < 10; i++) ps2_bit(bits[i], glitch && i == 3);
        ps2_dat = stop;
        wait_cyc(HALF);
        ps2_clk = 0;
        if (watch) begin
            check("lat_early", 32'(valid), 0);
            seen = 0;
            for (int k = 0; k < 16 && !seen; k++) begin
                wait_cyc(1);
                seen = valid;
            end
            check("lat_seen", 32'(seen), 1);
            check("lat_dat", 32'(dat), 32'(d));
            wait_cyc(HALF - 1);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1;
        ps2_dat = 1;
        wait_cyc(HALF);
        if ((^d) == par) exp_par++;
        else if (!stop) exp_frm++;
        else if (m_valid) exp_ovf++;
        else begin
            m_valid = 1;
            m_dat = d;
        end
    endtask

    task automatic consume();
        ready = 1;
        wait_cyc(1);
        ready = 0;
        m_valid = 0;
        wait_cyc(2);
    endtask

    initial begin
        bit [7:0] d;
        bit       p;
        bit       s;
        int       t0;
        int       dt;
        rst_n = 0;
        ps2_clk = 1;
        ps2_dat = 1;
        ready = 0;
        wait_cyc(5);
        check("rst_dat", 32'(dat), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_pulse", 32'({par_err, frm_err, ovf}), 0);
        rst_n = 1;
        wait_cyc(10);
        check_state("idle");

        frame(8'h1C, 0, 1, 0, 1);
        check_state("good1c");
        consume();
        check_state("take1c");

        frame(8'hF0, 1, 1, 0, 0);
        frame(8'h1C, 0, 1, 0, 0);
        check_state("ovf");
        consume();

        frame(8'h1C, 1, 1, 0, 0);
        check_state("parerr");
        frame(8'h5A, 1, 0, 0, 0);
        check_state("stoperr");

        for (int i = 0; i < 4; i++) ps2_bit(i == 2, 0);
        t0 = cyc - HALF;
        for (int k = 0; k < TMO + 100 && n_frm == exp_frm; k++) wait_cyc(1);
        exp_frm++;
        dt = frm_at - t0;
        check("tmo_win", 32'(dt >= TMO && dt <= TMO + 15), 1);
        wait_cyc(10);
        check_state("tmo");
        frame(8'h5A, 1, 1, 0, 0);
        check_state("after_tmo");
        consume();

        frame(8'h29, 0, 1, 1, 0);
        check_state("glitch29");
        consume();

        for (int i = 0; i < 6; i++) ps2_bit(i == 1 || i == 4, 0);
        rst_n = 0;
        wait_cyc(3);
        check("mid_rst_out", 32'({dat, valid, par_err, frm_err, ovf}), 0);
        rst_n = 1;
        m_valid = 0;
        m_dat = 0;
        wait_cyc(10);
        check_state("mid_rst");
        frame(8'h12, 1, 1, 0, 0);
        check_state("after_rst");

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            p = ~(^d);
            if ($urandom_range(3) == 0) p = ~p;
            s = ($urandom_range(3) != 0);
            frame(d, p, s, $urandom_range(3) == 0, 0);
            check_state("rand");
            if ($urandom_range(1) == 1) consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_core.md
Name: ps2_rx_core

Overview:
- PS/2 device-to-host receive engine that sits directly upstream of the APB4 PS/2 keyboard wrapper.
- Synchronises and filters the raw ps2_clk_i/ps2_dat_i lines, deserialises 11-bit frames, checks parity and stop bit, and presents each received scan-code byte on a valid/ready interface.
- The wrapper consumes these bytes into its FIFO/registers and derives irq_o from valid_o and the error pulses.

Parameters:
- FILT_LEN, 4, consecutive identical synchronised samples required before the filtered PS/2 clock changes (>=1).
- TIMEOUT_CYC, 2000, clk_i cycles allowed between falling edges inside a frame before the frame is aborted (>=16).

Ports:
- clk_i  input  1  system clock (pclk domain).
- rst_n_i  input  1  asynchronous active-low reset.
- ps2_clk_i  input  1  raw PS/2 clock line, asynchronous.
- ps2_dat_i  input  1  raw PS/2 data line, asynchronous.
- dat_o  output  8  received byte.
- valid_o  output  1  dat_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts dat_o when valid_o & ready_i.
- par_err_o  output  1  one-cycle pulse: frame dropped for bad parity.
- frm_err_o  output  1  one-cycle pulse: frame dropped for bad stop bit or timeout.
- ovf_o  output  1  one-cycle pulse: good byte dropped because the output was full.

Behaviour:
- Reset:
  - dat_o=0, valid_o=0, all pulse outputs 0, FSM=IDLE.
  - Synchroniser flops and filtered clock reset to 1. Bit counter and timeout counter reset to 0.
- Reset may assert at any point mid-frame. The partial frame is discarded with no error pulse.
- Input conditioning:
  - Both lines pass through a 2-flop synchroniser.
  - The filtered clock takes the synchronised clock value only after FILT_LEN consecutive equal samples.
  - fall = filtered clock 1->0, a single-cycle strobe.
  - The data bit is the synchronised ps2_dat value in the fall cycle.
- FSM is advanced only on fall, except for timeout:
  - IDLE: data bit 0 -> DATA with bit count 0. Data bit 1 -> stay IDLE, no error (noise).
  - DATA: shift the bit into the shift register LSB-first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: -> IDLE and evaluate the frame:
    - parity good (odd parity: the XOR of the 8 data bits and the parity bit is 1) and stop bit 1 -> good byte.
    - parity bad -> par_err_o pulse.
    - parity good but stop bit 0 -> frm_err_o pulse.
    - When parity and stop are both bad, only par_err_o pulses.
- Timeout:
  - In any state other than IDLE, the counter increments every clk_i cycle and clears on fall.
  - When the counter reaches TIMEOUT_CYC-1: -> IDLE, frm_err_o pulse, counter cleared.
  - The counter is held at 0 while in IDLE.
- Latency: if fall on the stop bit occurs in cycle N, then valid_o/dat_o update, or the error/overflow pulse fires, in cycle N+1.
- Output buffer (single entry):
  - Good byte with valid_o=0 -> load dat_o, set valid_o.
  - Good byte with valid_o=1 & ready_i=1 in the same cycle -> load the new byte, valid_o stays 1.
  - Good byte with valid_o=1 & ready_i=0 -> keep the old dat_o, ovf_o pulse.
  - valid_o & ready_i with no new byte -> valid_o=0 next cycle. dat_o holds its value.
  - dat_o is stable whenever valid_o=1 and ready_i=0.
- Host-to-device (inhibit/transmit) is out of scope. The lines are inputs only.

Test Plan:
- Good frame 0x1C (start 0, bits LSB-first, parity 0, stop 1), ready_i=0 -> valid_o=1 and dat_o=0x1C one cycle after the stop-bit fall, no pulses. Then ready_i=1 for one cycle -> valid_o=0.
- Back-to-back frames 0xF0 (parity 1) and 0x1C with ready_i held 0 -> dat_o=0xF0 held, ovf_o pulses once after the second frame, valid_o stays 1.
- Frame 0x1C with parity bit 1 -> par_err_o single pulse, valid_o stays 0. Frame 0x5A with stop bit 0 -> frm_err_o single pulse, no valid.
- Four clock edges, then the line idles high for TIMEOUT_CYC cycles -> frm_err_o pulse at the TIMEOUT_CYC-th cycle after the last fall. A following 0x5A frame (parity 1) is received correctly.
- Superimpose glitches on the clock line with FILT_LEN=4: a 2-cycle low glitch during idle and a 3-cycle high glitch inside a low phase -> no extra bits sampled, and frame 0x29 is received intact.
- Assert rst_n_i after 5 data bits of a frame, then release -> all outputs 0, no pulses. The next full frame 0x12 is received correctly.
